// File: rtl/axi_llc_pkg.sv
// Shared LLC AXI types and helpers used by the Ax request arbiter and its counters.
package axi_llc_pkg;

    localparam int AxIdWidth   = 4;
    localparam int AxAddrWidth = 32;

    // Base ID used by LLC-internal Ax requesters; the arbiter overwrites the low index bits.
    localparam logic [AxIdWidth-1:0] AxReqId = '0;

    typedef struct packed {
        logic [AxIdWidth-1:0]   id;
        logic [AxAddrWidth-1:0] addr;
        logic [7:0]             len;
        logic [2:0]             size;
        logic [1:0]             burst;
    } ax_chan_t;

    function automatic int ArbIdxWidth(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/axi_llc_credit_cnt.sv
// Outstanding-burst credit counter for one requester; registered, saturates at MaxTrans and 0.
// Simultaneous inc and dec leave the count unchanged.
module axi_llc_credit_cnt #(
    parameter int MaxTrans = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic at_max,
    output logic is_zero
);

    localparam int CW = $clog2(MaxTrans + 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (inc && !dec && !at_max) begin
            cnt_q <= cnt_q + CW'(1);
        end else if (dec && !inc && !is_zero) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign at_max  = (cnt_q == CW'(MaxTrans));
    assign is_zero = (cnt_q == '0);

endmodule

// File: rtl/axi_llc_ax_arbiter.sv
// Round-robin merge of NumReq Ax streams into one registered master Ax channel (1-cycle latency),
// credit-limited per requester; no grant while the output register is stalled by mst_ready_i.
module axi_llc_ax_arbiter #(
    parameter int  NumReq    = 2,
    parameter int  MaxTrans  = 4,
    parameter int  IdWidth   = 4,
    parameter type ax_chan_t = axi_llc_pkg::ax_chan_t
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  ax_chan_t          req_ax_i [NumReq],
    input  logic [NumReq-1:0] req_valid_i,
    output logic [NumReq-1:0] req_ready_o,
    output ax_chan_t          mst_ax_o,
    output logic              mst_valid_o,
    input  logic              mst_ready_i,
    input  logic              done_valid_i,
    input  logic [IdWidth-1:0] done_id_i,
    output logic [NumReq-1:0] done_o,
    output logic              idle_o,
    output logic              err_o
);

    import axi_llc_pkg::*;

    localparam int IW = ArbIdxWidth(NumReq);

    logic [IW-1:0]     prio_q, gnt_idx, rr_idx, next_prio, done_idx;
    logic              found, load, issue, done_hit, spurious;
    logic [NumReq-1:0] elig, at_max, is_zero, inc, dec;
    ax_chan_t          out_q, gnt_ax;
    logic              out_valid_q, err_q;
    logic              unused_id_bits;

    assign load = !out_valid_q || mst_ready_i;
    assign elig = req_valid_i & ~at_max;

    // Rotate by prio_q, take the first eligible slot, and map it back to a requester index.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        rr_idx  = '0;
        for (int i = 0; i < NumReq; i++) begin
            rr_idx = IW'((i + int'(prio_q)) % NumReq);
            if (!found && elig[rr_idx]) begin
                found   = 1'b1;
                gnt_idx = rr_idx;
            end
        end
    end

    assign issue     = load && found;
    assign next_prio = IW'((int'(gnt_idx) + 1) % NumReq);

    always_comb begin
        req_ready_o = '0;
        if (issue) begin
            req_ready_o[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        gnt_ax            = req_ax_i[gnt_idx];
        gnt_ax.id[IW-1:0] = gnt_idx;
    end

    assign done_idx       = done_id_i[IW-1:0];
    assign unused_id_bits = ^done_id_i[IdWidth-1:IW];

    // done_o fires even on a spurious completion; only the counter update is suppressed.
    always_comb begin
        done_o   = '0;
        dec      = '0;
        inc      = '0;
        done_hit = 1'b0;
        spurious = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            inc[i] = issue && (gnt_idx == IW'(i));
            if (done_valid_i && (done_idx == IW'(i))) begin
                done_hit  = 1'b1;
                done_o[i] = 1'b1;
                dec[i]    = !is_zero[i];
                spurious  = is_zero[i];
            end
        end
        if (done_valid_i && !done_hit) begin
            spurious = 1'b1;
        end
    end

    for (genvar g = 0; g < NumReq; g++) begin : g_cnt
        axi_llc_credit_cnt #(
            .MaxTrans (MaxTrans)
        ) u_cnt (
            .clk     (clk_i),
            .rst     (rst_i),
            .inc     (inc[g]),
            .dec     (dec[g]),
            .at_max  (at_max[g]),
            .is_zero (is_zero[g])
        );
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            prio_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            if (issue) begin
                out_q  <= gnt_ax;
                prio_q <= next_prio;
            end
            if (load) begin
                out_valid_q <= issue;
            end
            if (spurious) begin
                err_q <= 1'b1;
            end
        end
    end

    assign mst_ax_o    = out_q;
    assign mst_valid_o = out_valid_q;
    assign idle_o      = !out_valid_q && (&is_zero);
    assign err_o       = err_q;

endmodule

// File: tb/tb_axi_llc_ax_arbiter.sv
// Directed bench for axi_llc_ax_arbiter with NumReq=2, MaxTrans=4, IdWidth=4.
module tb_axi_llc_ax_arbiter;

    import axi_llc_pkg::*;

    logic       clk;
    logic       rst;
    ax_chan_t   req_ax [2];
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    ax_chan_t   mst_ax;
    logic       mst_valid;
    logic       mst_ready;
    logic       done_valid;
    logic [3:0] done_id;
    logic [1:0] done;
    logic       idle;
    logic       err;

    int tests;
    int fails;

    axi_llc_ax_arbiter #(
        .NumReq   (2),
        .MaxTrans (4),
        .IdWidth  (4)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_ax_i     (req_ax),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .mst_ax_o     (mst_ax),
        .mst_valid_o  (mst_valid),
        .mst_ready_i  (mst_ready),
        .done_valid_i (done_valid),
        .done_id_i    (done_id),
        .done_o       (done),
        .idle_o       (idle),
        .err_o        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ax_chan_t mk_ax(input logic [3:0] id, input logic [31:0] addr);
        ax_chan_t a;
        a       = '0;
        a.id    = id;
        a.addr  = addr;
        a.len   = 8'd3;
        a.size  = 3'd3;
        a.burst = 2'b01;
        return a;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic complete(input logic [3:0] id);
        done_valid = 1'b1;
        done_id    = id;
        tick();
        done_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        tests++; if (mst_valid !== 1'b0) begin fails++; $display("FAIL reset_mst_valid got %b exp 0", mst_valid); end
        tests++; if (mst_ax !== '0) begin fails++; $display("FAIL reset_mst_ax got %h exp 0", mst_ax); end
        tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL reset_req_ready got %b exp 00", req_ready); end
        tests++; if (done !== 2'b00) begin fails++; $display("FAIL reset_done got %b exp 00", done); end
        tests++; if (idle !== 1'b1) begin fails++; $display("FAIL reset_idle got %b exp 1", idle); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b exp 0", err); end
        tick();
        rst = 1'b0;
        tick();
        tests++; if (idle !== 1'b1 || mst_valid !== 1'b0) begin fails++; $display("FAIL post_reset_idle got idle=%b vld=%b exp 1/0", idle, mst_valid); end
    endtask

    task automatic test_single_issue();
        mst_ready = 1'b0;
        req_ax[0] = mk_ax(4'h4, 32'h1000);
        req_valid = 2'b01;
        #1;
        tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL single_ready got %b exp 01", req_ready); end
        tests++; if (mst_valid !== 1'b0) begin fails++; $display("FAIL single_no_comb_valid got %b exp 0", mst_valid); end
        tick();
        req_valid = 2'b00;
        tests++; if (mst_valid !== 1'b1) begin fails++; $display("FAIL single_mst_valid got %b exp 1", mst_valid); end
        tests++; if (mst_ax.id !== 4'h4) begin fails++; $display("FAIL single_id got %h exp 4", mst_ax.id); end
        tests++; if (mst_ax.addr !== 32'h1000) begin fails++; $display("FAIL single_addr got %h exp 1000", mst_ax.addr); end
        tests++; if (idle !== 1'b0) begin fails++; $display("FAIL single_busy got %b exp 0", idle); end
        mst_ready = 1'b1;
        tick();
        tests++; if (mst_valid !== 1'b0 || idle !== 1'b0) begin fails++; $display("FAIL single_drain got vld=%b idle=%b exp 0/0", mst_valid, idle); end
        done_valid = 1'b1;
        done_id    = 4'h4;
        #1;
        tests++; if (done !== 2'b01) begin fails++; $display("FAIL single_done got %b exp 01", done); end
        tick();
        done_valid = 1'b0;
        tests++; if (idle !== 1'b1 || err !== 1'b0) begin fails++; $display("FAIL single_idle got idle=%b err=%b exp 1/0", idle, err); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_id;
        int exp_g;
        exp_g = 1;
        mst_ready = 1'b1;
        req_ax[0] = mk_ax(4'h2, 32'hA000);
        req_ax[1] = mk_ax(4'h2, 32'hB000);
        req_valid = 2'b11;
        for (int c = 0; c < 4; c++) begin
            #1;
            tests++; if (req_ready !== 2'(1 << exp_g)) begin fails++; $display("FAIL rr_grant[%0d] got %b exp %0d", c, req_ready, exp_g); end
            tick();
            exp_id = (exp_g == 1) ? 4'h3 : 4'h2;
            tests++; if (mst_valid !== 1'b1 || mst_ax.id !== exp_id) begin fails++; $display("FAIL rr_id[%0d] got vld=%b id=%h exp 1/%h", c, mst_valid, mst_ax.id, exp_id); end
            exp_g = 1 - exp_g;
        end
        req_valid = 2'b00;
        tick();
        complete(4'h0);
        complete(4'h0);
        complete(4'h1);
        complete(4'h1);
        tests++; if (idle !== 1'b1 || err !== 1'b0) begin fails++; $display("FAIL rr_cleanup got idle=%b err=%b exp 1/0", idle, err); end
    endtask

    task automatic test_backpressure();
        mst_ready = 1'b0;
        req_ax[0] = mk_ax(4'h0, 32'h2000);
        req_ax[1] = mk_ax(4'h0, 32'h3000);
        req_valid = 2'b01;
        #1;
        tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL bp_first_grant got %b exp 01", req_ready); end
        tick();
        req_ax[0] = mk_ax(4'h0, 32'h2100);
        req_valid = 2'b11;
        for (int c = 0; c < 5; c++) begin
            #1;
            tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL bp_ready[%0d] got %b exp 00", c, req_ready); end
            tests++; if (mst_valid !== 1'b1 || mst_ax.addr !== 32'h2000) begin fails++; $display("FAIL bp_hold[%0d] got vld=%b addr=%h exp 1/2000", c, mst_valid, mst_ax.addr); end
            tick();
        end
        mst_ready = 1'b1;
        #1;
        tests++; if (req_ready !== 2'b10) begin fails++; $display("FAIL bp_release got %b exp 10", req_ready); end
        tick();
        req_valid = 2'b00;
        tests++; if (mst_valid !== 1'b1 || mst_ax.addr !== 32'h3000 || mst_ax.id !== 4'h1) begin fails++; $display("FAIL bp_next got vld=%b addr=%h id=%h exp 1/3000/1", mst_valid, mst_ax.addr, mst_ax.id); end
        tick();
        complete(4'h0);
        complete(4'h1);
        tests++; if (idle !== 1'b1 || err !== 1'b0) begin fails++; $display("FAIL bp_cleanup got idle=%b err=%b exp 1/0", idle, err); end
    endtask

    task automatic test_credit_limit();
        mst_ready = 1'b1;
        req_ax[0] = mk_ax(4'h8, 32'h4000);
        req_ax[1] = mk_ax(4'h8, 32'h5000);
        req_valid = 2'b10;
        for (int c = 0; c < 4; c++) begin
            #1;
            tests++; if (req_ready !== 2'b10) begin fails++; $display("FAIL cr_fill[%0d] got %b exp 10", c, req_ready); end
            tick();
        end
        req_valid = 2'b11;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL cr_excluded[%0d] got %b exp 01", c, req_ready); end
            tick();
        end
        done_valid = 1'b1;
        done_id    = 4'h1;
        #1;
        tests++; if (req_ready !== 2'b01 || done !== 2'b10) begin fails++; $display("FAIL cr_free got ready=%b done=%b exp 01/10", req_ready, done); end
        tick();
        done_valid = 1'b0;
        #1;
        tests++; if (req_ready !== 2'b10) begin fails++; $display("FAIL cr_regrant got %b exp 10", req_ready); end
        tick();
        req_valid = 2'b00;
        tick();
        for (int c = 0; c < 4; c++) begin
            complete(4'h0);
            complete(4'h1);
        end
        tests++; if (idle !== 1'b1 || err !== 1'b0) begin fails++; $display("FAIL cr_cleanup got idle=%b err=%b exp 1/0", idle, err); end
    endtask

    task automatic test_simultaneous();
        int grants;
        mst_ready = 1'b1;
        req_ax[0] = mk_ax(4'h0, 32'h6000);
        req_valid = 2'b01;
        tick();
        tick();
        done_valid = 1'b1;
        done_id    = 4'h0;
        #1;
        tests++; if (req_ready !== 2'b01 || done !== 2'b01) begin fails++; $display("FAIL sim_same_cycle got ready=%b done=%b exp 01/01", req_ready, done); end
        tick();
        done_valid = 1'b0;
        grants = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (req_ready[0] === 1'b1) grants++;
            tick();
        end
        tests++; if (grants !== 2) begin fails++; $display("FAIL sim_count_kept got %0d more grants exp 2", grants); end
        req_valid = 2'b00;
        tick();
        for (int c = 0; c < 4; c++) complete(4'h0);
        tests++; if (idle !== 1'b1 || err !== 1'b0) begin fails++; $display("FAIL sim_cleanup got idle=%b err=%b exp 1/0", idle, err); end
    endtask

    task automatic test_spurious_reset();
        mst_ready  = 1'b0;
        done_valid = 1'b1;
        done_id    = 4'h1;
        #1;
        tests++; if (done !== 2'b10) begin fails++; $display("FAIL spur_done got %b exp 10", done); end
        tick();
        done_valid = 1'b0;
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL spur_err got %b exp 1", err); end
        tick();
        tests++; if (err !== 1'b1 || idle !== 1'b1) begin fails++; $display("FAIL spur_sticky got err=%b idle=%b exp 1/1", err, idle); end
        req_ax[0] = mk_ax(4'h0, 32'h7000);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tests++; if (mst_valid !== 1'b1) begin fails++; $display("FAIL rst_pre_valid got %b exp 1", mst_valid); end
        #1;
        rst = 1'b1;
        #1;
        tests++; if (mst_valid !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL rst_async got vld=%b err=%b exp 0/0", mst_valid, err); end
        tests++; if (idle !== 1'b1 || mst_ax !== '0) begin fails++; $display("FAIL rst_async_state got idle=%b ax=%h exp 1/0", idle, mst_ax); end
        tick();
        rst = 1'b0;
        tick();
        tests++; if (mst_valid !== 1'b0 || idle !== 1'b1 || err !== 1'b0) begin fails++; $display("FAIL rst_release got vld=%b idle=%b err=%b exp 0/1/0", mst_valid, idle, err); end
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        rst        = 1'b1;
        req_ax[0]  = '0;
        req_ax[1]  = '0;
        req_valid  = 2'b00;
        mst_ready  = 1'b0;
        done_valid = 1'b0;
        done_id    = 4'h0;
        test_reset();
        test_single_issue();
        test_round_robin();
        test_backpressure();
        test_credit_limit();
        test_simultaneous();
        test_spurious_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi_llc_ax_arbiter.md
# axi_llc_ax_arbiter

Merges `NumReq` independent Ax request streams onto one AXI master AW or AR channel of the LLC. Typical requesters are the per-partition eviction or refill Ax masters. The block arbitrates round-robin and tags each burst's ID with the requester index. It tracks outstanding bursts per requester with credit counters and routes completion events (B handshake, or R handshake with `last`) back to the issuing requester.

## Interface
- `NumReq`, 2: number of requesters, ≥2.
- `MaxTrans`, 4: maximum outstanding bursts per requester, ≥1.
- `IdWidth`, 4: master-port ID width. Must satisfy `IdWidth > $clog2(NumReq)`.
- `ax_chan_t`, logic: AXI Ax channel struct of the master port.
- `clk_i` in 1: clock, positive edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `req_ax_i` in `NumReq`×`ax_chan_t`: requester Ax payloads.
- `req_valid_i` in `NumReq`: requester valid.
- `req_ready_o` out `NumReq`: requester ready.
- `mst_ax_o` out `ax_chan_t`: merged Ax payload.
- `mst_valid_o` out 1: merged valid.
- `mst_ready_i` in 1: merged ready.
- `done_valid_i` in 1: one burst completed on the master port. This is a single-cycle pulse.
- `done_id_i` in `IdWidth`: ID of the completed burst.
- `done_o` out `NumReq`: one-hot completion pulse to the owning requester.
- `idle_o` out 1: no burst pending in the output register and all counters are zero.
- `err_o` out 1: sticky flag, set when a completion arrives for a requester whose counter is zero.

## Operation
- **Eligibility.** Requester i is eligible when `req_valid_i[i]` is high and `cnt[i] < MaxTrans`.
- **Output register.** A single-entry register holds `out_q` and `out_valid_q`. The register can load when `!out_valid_q`, or when `out_valid_q && mst_ready_i`.
- **Arbitration.**
  - When the register can load and at least one requester is eligible, select the first eligible index at or after `prio_q`, searching upward with wrap-around.
  - Assert `req_ready_o` only for the selected index, combinationally, in the same cycle.
  - All other `req_ready_o` bits are 0.
- **Issue.** When `req_valid_i[g] && req_ready_o[g]`:
  - Load `out_q = req_ax_i[g]`, with `id[$clog2(NumReq)-1:0]` replaced by g. Upper ID bits pass through unchanged.
  - Set `out_valid_q = 1`.
  - Increment `cnt[g]`.
  - Set `prio_q = (g+1) mod NumReq`.
- **Stability.** While `out_valid_q && !mst_ready_i`, `mst_ax_o` is held stable and no requester is granted. This satisfies the AXI stability rule.
- **Drain.** When `mst_ready_i` is high with no new grant, `out_valid_q` clears on the next edge.
- **Completion.** On `done_valid_i`, decode `k = done_id_i[$clog2(NumReq)-1:0]`.
  - If `k ≥ NumReq`, ignore the completion and set `err_o`.
  - If `cnt[k] == 0`, set `err_o`. The counter stays at 0 and `done_o` is still pulsed.
  - Otherwise, pulse `done_o[k]` combinationally in the same cycle and decrement `cnt[k]`.
- **Simultaneous events.** When issue and completion hit the same counter in one cycle, the counter is unchanged.
- **Counter range.** Counters are `$clog2(MaxTrans+1)` bits wide, saturate by construction, and never wrap.
- **Idle.** `idle_o = !out_valid_q && (all cnt == 0)`.

## Timing
- **Latency.** A request accepted in cycle N appears on `mst_valid_o` at cycle N+1.
- **Throughput.** With `mst_ready_i` held high, the block sustains one burst per cycle.
- **Combinational paths.**
  - `req_valid_i` → `req_ready_o`.
  - `mst_ready_i` → `req_ready_o`.
  - `done_*` → `done_o`.
  - There is no path from `req_valid_i` to `mst_valid_o`.
- **Credit timing.** A credit freed by a completion in cycle N makes the requester eligible in cycle N+1. The decremented counter is registered.
- **Reset values.** `mst_valid_o=0`, `mst_ax_o='0`, `req_ready_o=0`, `done_o=0` (no completion), `idle_o=1`, `err_o=0`, `prio_q=0`, all `cnt=0`.
- **Reset mid-operation.** Reset drops any pending burst and all credits immediately (asynchronous). Completions for bursts issued before reset are ignored until `err_o` is evaluated; the integrator must quiesce the downstream port.

## Structure
- **Shared package.** Add `ArbIdxWidth(NumReq)`, a helper giving `$clog2(NumReq)` with a minimum of 1, to `axi_llc_pkg`. The `AxReqId` ID base stays there.
- **Sub-module.** One sub-module, `axi_llc_credit_cnt`: a single up/down counter with an inc, dec and max-compare output. Instantiate it `NumReq` times.
- **Round-robin selection.** Implement the selection inline as a rotate, priority-pick, unrotate sequence. This avoids a cross-cycle lock, because the grant is decided only when the register can load.

## Test plan
- **Reset and single issue.** Reset, then `req_valid_i=2'b01` with `addr=0x1000`, `id=0x4`. Expect `req_ready_o[0]` in cycle 1 and `mst_valid_o` at cycle 2 with `id=0x4`. Pulse `done` with `id=0x4`: expect `done_o=2'b01`, with `idle_o=1` after the completion.
- **Round-robin fairness.** Both requesters valid continuously, `mst_ready_i=1`. Expect the grant pattern 0,1,0,1… and master IDs with LSB alternating 0/1.
- **Backpressure.** `mst_ready_i=0` for 5 cycles with the output register full. Expect `mst_ax_o` stable, `req_ready_o=0` for those cycles, and release one cycle after `mst_ready_i` rises.
- **Credit limit.** `MaxTrans=4`, requester 1 issues 4 bursts with no completions. Expect requester 1 excluded while requester 0 is still served. One completion with `id=0x1` → requester 1 is granted one cycle later.
- **Simultaneous issue and completion.** Requester 0 issues in the same cycle as `done_valid_i` with `id=0x0` while `cnt[0]=2`. Expect `cnt[0]` to remain 2 and `done_o=2'b01`.
- **Spurious completion and async reset.** Completion with `id=0x1` while `cnt[1]=0` → `err_o=1`, sticky. Assert `rst_i` mid-burst → `mst_valid_o=0` and `err_o=0` asynchronously, without waiting for a clock edge.
